ram_arbiter_2port: RTL and testbench

Two-requester round-robin scheduler that shares the single-port 16-word x 16-bit synchronous RAM (`din`, `en`, `wen`, `clk`, `address`, `out`) between two independent clients. Each client issues single-word read or write commands over a req/gnt handshake. The block sequences the RAM control pins and returns read data with a one-cycle valid strobe. It sits directly in front of the RAM instance; clients never drive the RAM themselves.

---
 rtl/ram_arb_pkg.sv | 15 +
 rtl/rr_arb2.sv | 17 +
 rtl/ram_arbiter_2port.sv | 145 ++++++++++++++
 tb/tb_ram_arbiter_2port.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the two-client RAM arbiter.
package ram_arb_pkg;
   localparam int DEF_DATA_W = 16;
   localparam int DEF_ADDR_W = 4;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_RDATA = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      ISSUE = ST_ISSUE,
      RDATA = ST_RDATA
   } state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin winner select; a tie goes to the port that was not served last.
module rr_arb2 (
   input  logic       req0,
   input  logic       req1,
   input  logic       last,
   output logic [1:0] win
);
   always_comb begin
      win = 2'b00;
      if (req0 && req1)
         win = last ? 2'b01 : 2'b10;
      else if (req0)
         win = 2'b01;
      else if (req1)
         win = 2'b10;
   end
endmodule

// File: rtl/ram_arbiter_2port.sv
// Shares one single-port synchronous RAM between two req/gnt clients, one
// command at a time; read data comes back with a one-cycle valid strobe.
module ram_arbiter_2port
   import ram_arb_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic              busy,
   output logic [DATA_W-1:0] ram_din,
   output logic              ram_en,
   output logic              ram_wen,
   output logic [ADDR_W-1:0] ram_address,
   input  logic [DATA_W-1:0] ram_out
);
   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } cmd_t;

   cmd_t [1:0]             cmd;
   cmd_t                   sel;
   logic [1:0]             win;
   state_t                 state, state_nx;
   logic                   last, last_nx;
   logic                   owner, owner_nx;
   logic                   op, op_nx;
   logic [1:0]             gnt, gnt_nx;
   logic [1:0]             rvalid, rvalid_nx;
   logic [1:0][DATA_W-1:0] rdata, rdata_nx;
   logic                   en_nx, wen_nx, busy_nx;
   logic [ADDR_W-1:0]      addr_nx;
   logic [DATA_W-1:0]      din_nx;

   assign cmd[0] = '{we: we0, addr: addr0, wdata: wdata0};
   assign cmd[1] = '{we: we1, addr: addr1, wdata: wdata1};
   assign sel    = cmd[win[1]];

   rr_arb2 u_arb (
      .req0 (req0),
      .req1 (req1),
      .last (last),
      .win  (win)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Every output is a register; this block only computes their next values.
   always_comb begin
      state_nx  = state;
      last_nx   = last;
      owner_nx  = owner;
      op_nx     = op;
      gnt_nx    = 2'b00;
      rvalid_nx = 2'b00;
      rdata_nx  = rdata;
      en_nx     = ram_en;
      wen_nx    = ram_wen;
      addr_nx   = ram_address;
      din_nx    = ram_din;
      case (state)
         IDLE: begin
            en_nx = 1'b0;
            if (|win) begin
               owner_nx = win[1];
               op_nx    = sel.we;
               gnt_nx   = win;
               en_nx    = 1'b1;
               wen_nx   = sel.we;
               addr_nx  = sel.addr;
               din_nx   = sel.wdata;
               state_nx = ISSUE;
            end
         end
         ISSUE: begin
            en_nx    = 1'b0;
            wen_nx   = 1'b0;
            last_nx  = owner;
            state_nx = op ? IDLE : RDATA;
         end
         RDATA: begin
            rdata_nx[owner]  = ram_out;
            rvalid_nx[owner] = 1'b1;
            state_nx         = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      busy_nx = (state_nx != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last        <= 1'b1;
         owner       <= 1'b0;
         op          <= 1'b0;
         gnt         <= 2'b00;
         rvalid      <= 2'b00;
         rdata       <= '0;
         busy        <= 1'b0;
         ram_en      <= 1'b0;
         ram_wen     <= 1'b0;
         ram_address <= '0;
         ram_din     <= '0;
      end else begin
         last        <= last_nx;
         owner       <= owner_nx;
         op          <= op_nx;
         gnt         <= gnt_nx;
         rvalid      <= rvalid_nx;
         rdata       <= rdata_nx;
         busy        <= busy_nx;
         ram_en      <= en_nx;
         ram_wen     <= wen_nx;
         ram_address <= addr_nx;
         ram_din     <= din_nx;
      end
   end

   assign gnt0    = gnt[0];
   assign gnt1    = gnt[1];
   assign rvalid0 = rvalid[0];
   assign rvalid1 = rvalid[1];
   assign rdata0  = rdata[0];
   assign rdata1  = rdata[1];
endmodule

// File: tb/tb_ram_arbiter_2port.sv
// Bench for ram_arbiter_2port: directed scenarios plus random client traffic,
// all checked every cycle against a transaction-level model with its own RAM image.
module tb_ram_arbiter_2port;
   localparam int DW = 16;
   localparam int AW = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [1:0]         req = '0;
   logic [1:0]         we = '0;
   logic [1:0][AW-1:0] addr = '0;
   logic [1:0][DW-1:0] wdata = '0;
   logic               gnt0, gnt1, rvalid0, rvalid1, busy, ram_en, ram_wen;
   logic [DW-1:0]      rdata0, rdata1, ram_din, ram_out;
   logic [AW-1:0]      ram_address;
   logic [DW-1:0]      ram [16];

   wire [1:0] gv = {gnt1, gnt0};
   wire [1:0] rv = {rvalid1, rvalid0};

   // RAM model: output registered on a read edge, contents survive reset
   always @(posedge clk)
      if (ram_en) begin
         if (ram_wen) ram[ram_address] <= ram_din;
         else         ram_out <= ram[ram_address];
      end

   ram_arbiter_2port #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst),
      .req0(req[0]), .req1(req[1]), .we0(we[0]), .we1(we[1]),
      .addr0(addr[0]), .addr1(addr[1]), .wdata0(wdata[0]), .wdata1(wdata[1]),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
      .ram_din(ram_din), .ram_en(ram_en), .ram_wen(ram_wen),
      .ram_address(ram_address), .ram_out(ram_out)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, exp %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int                 cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [DW-1:0]      m_mem [16];
   logic [1:0][DW-1:0] m_rdata;
   logic               m_last;
   int                 nxt_idle;
   logic               p_vld, p_port, p_we;
   int                 p_cyc;
   logic [AW-1:0]      p_addr;
   logic [DW-1:0]      p_data;
   logic               rv_vld, rv_port;
   int                 rv_cyc;
   logic [DW-1:0]      rv_data;
   logic               s_vld, s_idle;
   logic [1:0]         s_req, s_we;
   logic [1:0][AW-1:0] s_addr;
   logic [1:0][DW-1:0] s_wdata;
   logic [1:0]         gseen;
   logic [1:0]         e_gnt, e_rv;
   int                 w;

   initial begin
      for (int i = 0; i < 16; i++) m_mem[i] = '0;
      m_rdata = '0; m_last = 1'b1; nxt_idle = 0;
      p_vld = 1'b0; rv_vld = 1'b0; s_vld = 1'b0; gseen = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            chk("rst_ctl", {gnt0, gnt1, rvalid0, rvalid1, busy, ram_en, ram_wen}, 0);
            chk("rst_ram", {ram_address, ram_din}, 0);
            chk("rst_rdata", {rdata1, rdata0}, 0);
            m_rdata = '0; m_last = 1'b1; nxt_idle = 0;
            p_vld = 1'b0; rv_vld = 1'b0; s_vld = 1'b0; gseen = '0;
         end else begin
            // command granted last cycle was executed by the RAM at the edge just passed
            if (p_vld && p_cyc == cyc) begin
               p_vld = 1'b0;
               if (p_we) m_mem[p_addr] = p_data;
               else begin
                  rv_vld = 1'b1; rv_cyc = cyc + 1; rv_port = p_port; rv_data = m_mem[p_addr];
               end
            end
            e_gnt = '0;
            if (s_vld && s_idle && s_req != 2'b00) begin
               if (s_req == 2'b11) w = m_last ? 0 : 1;
               else                w = s_req[1] ? 1 : 0;
               e_gnt[w] = 1'b1;
               m_last   = w[0];
               p_vld = 1'b1; p_cyc = cyc + 1; p_port = w[0];
               p_we = s_we[w]; p_addr = s_addr[w]; p_data = s_wdata[w];
               nxt_idle = s_we[w] ? cyc + 1 : cyc + 2;
            end
            e_rv = '0;
            if (rv_vld && rv_cyc == cyc) begin
               e_rv[rv_port] = 1'b1;
               m_rdata[rv_port] = rv_data;
               rv_vld = 1'b0;
            end
            chk("gnt", gv, e_gnt);
            chk("rvalid", rv, e_rv);
            chk("rdata0", rdata0, m_rdata[0]);
            chk("rdata1", rdata1, m_rdata[1]);
            chk("busy", busy, cyc < nxt_idle);
            chk("ram_en", ram_en, e_gnt != 0);
            chk("ram_wen", ram_wen, (e_gnt != 0) && p_we);
            if (e_gnt != 0) chk("ram_cmd", {ram_address, ram_din}, {p_addr, p_data});
            s_vld = 1'b1; s_idle = (cyc >= nxt_idle);
            s_req = req; s_we = we; s_addr = addr; s_wdata = wdata;
            gseen = gv;
         end
      end
   end

   // ---------------- client helpers ----------------
   task automatic drv(input int p, input logic w_, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req[p] = 1'b1; we[p] = w_; addr[p] = a; wdata[p] = d;
   endtask

   task automatic wait_gnt(input int p, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!gv[p] && n < 30);
      chk("gnt_seen", gv[p], 1);
   endtask

   task automatic wait_rv(input int p, output logic [DW-1:0] d, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!rv[p] && n < 10);
      chk("rv_seen", rv[p], 1);
      d = p[0] ? rdata1 : rdata0;
   endtask

   task automatic send(input int p, input logic w_, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       output int lat);
      @(posedge clk); #1;
      drv(p, w_, a, d);
      wait_gnt(p, lat);
      @(posedge clk); #1;
      req[p] = 1'b0;
   endtask

   task automatic rd(input int p, input logic [AW-1:0] a, output logic [DW-1:0] d, output int lat);
      int gl;
      send(p, 1'b0, a, '0, gl);
      wait_rv(p, d, lat);
   endtask

   task automatic both(output int c0, output int c1);
      int         n;
      logic [1:0] g;
      n = 0; c0 = -1; c1 = -1;
      while ((c0 < 0 || c1 < 0) && n < 30) begin
         @(negedge clk);
         n++;
         g = gv;
         if (g[0]) c0 = n;
         if (g[1]) c1 = n;
         @(posedge clk); #1;
         if (g[0]) req[0] = 1'b0;
         if (g[1]) req[1] = 1'b0;
      end
      chk("both_gnt", {c1 > 0, c0 > 0}, 2'b11);
   endtask

   task automatic rst_pulse();
      #1 rst = 1'b1;
      req = '0;
      #1 chk("rst_async", {gnt0, gnt1, ram_en, ram_wen, busy}, 0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int            lat, n, c0, c1, ng;
      logic          prev, port;
      logic [DW-1:0] d;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;

      // tie right after reset: port 0 first, port 1 two cycles later
      @(posedge clk); #1;
      drv(0, 1'b1, 4'd5, 16'd7);
      drv(1, 1'b1, 4'd6, 16'd9);
      both(c0, c1);
      chk("tie_gap", c1 - c0, 2);

      // write and read of one address in the same cycle, last=1: write first
      @(posedge clk); #1;
      drv(0, 1'b1, 4'd3, 16'hBEEF);
      drv(1, 1'b0, 4'd3, 16'h0);
      both(c0, c1);
      chk("rw_order", c1 - c0, 2);
      wait_rv(1, d, n);
      chk("rw_data", d, 16'hBEEF);

      rd(0, 4'd5, d, n);
      chk("rb5", d, 16'd7);
      rd(1, 4'd6, d, n);
      chk("rb6", d, 16'd9);

      send(0, 1'b1, 4'd10, 16'd25, lat);
      chk("wr_gnt_lat", lat, 2);
      rd(0, 4'd10, d, n);
      chk("rd_lat", n, 2);
      chk("rd25", d, 16'd25);

      for (int a = 0; a < 16; a++)
         if (a != 3 && a != 5 && a != 6 && a != 10)
            send(a % 2, 1'b1, AW'(a), (a == 2) ? 16'h0011 : DW'(a * 16'h0101), lat);

      // reset while the write sits in ISSUE: it must not land
      @(posedge clk); #1;
      drv(0, 1'b1, 4'd2, 16'h1234);
      wait_gnt(0, n);
      rst_pulse();
      rd(1, 4'd2, d, n);
      chk("rst_wr_lost", d, 16'h0011);

      // reset while the read sits in RDATA: no rvalid, rdata cleared
      @(posedge clk); #1;
      drv(1, 1'b0, 4'd7, 16'h0);
      wait_gnt(1, n);
      @(posedge clk); #1;
      rst_pulse();
      ng = 0;
      repeat (4) begin
         @(negedge clk);
         if (rvalid1) ng++;
      end
      chk("rst_rd_norv", ng, 0);
      chk("rst_rd_rdata1", rdata1, 0);

      // continuous contention: strict alternation starting with port 0
      @(posedge clk); #1;
      drv(0, 1'b1, 4'd12, 16'hA0A0);
      drv(1, 1'b1, 4'd13, 16'h0B0B);
      ng = 0; n = 0; prev = 1'b0;
      while (ng < 8 && n < 40) begin
         @(negedge clk);
         n++;
         if (gv != 2'b00) begin
            port = gv[1];
            if (ng == 0) chk("cont_first", port, 0);
            else         chk("cont_alt", port, !prev);
            prev = port;
            ng++;
         end
      end
      @(posedge clk); #1;
      req = '0;
      chk("cont_grants", ng, 8);

      // random traffic under the client rules
      repeat (600) begin
         @(posedge clk); #1;
         for (int p = 0; p < 2; p++)
            if (!req[p] || gseen[p]) begin
               if ($urandom_range(3) != 0)
                  drv(p, 1'($urandom_range(1)), AW'($urandom_range(15)), DW'($urandom));
               else
                  req[p] = 1'b0;
            end
      end
      req = '0;
      repeat (6) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
